sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//   Central arbiter between the SDRAM init, refresh, write and read sub-controllers and the SDRAM pins.
//   - Grants one requester at a time with a one-cycle enable pulse.
//   - Muxes the granted block's cmd/addr/bank onto the SDRAM bus.
//   - Drives DQ output-enable for writes.
//   - Captures read data after CAS latency and hands it downstream to the UART TX path.
// PARAMETERS
//   DATA_WIDTH  16       SDRAM DQ width
//   ADDR_WIDTH  12       SDRAM address width
//   CAS_LAT     3        CAS latency in clk cycles (2 or 3)
//   CMD_NOP     4'b0111  {cs_n,ras_n,cas_n,we_n} NOP encoding
//   CMD_READ    4'b0101  READ encoding
//   CMD_WRITE   4'b0100  WRITE encoding
// PORTS
//   clk           in   1           system clock (also the SDRAM clock)
//   rst_n         in   1           asynchronous reset, active-low
//   init_end      in   1           init sequence complete (level)
//   init_cmd      in   4           init command
//   init_addr     in   ADDR_WIDTH  init address
//   ref_rq        in   1           refresh request (level, held until ref_en)
//   ref_end       in   1           refresh finished (1-cycle pulse)
//   ref_cmd       in   4           refresh command
//   ref_addr      in   ADDR_WIDTH  refresh address
//   ref_en        out  1           refresh grant pulse
//   wr_rq         in   1           write request (level, held until wr_en)
//   wr_end        in   1           write finished (pulse)
//   wr_cmd        in   4           write command
//   wr_addr       in   ADDR_WIDTH  write address
//   wr_bank_addr  in   2           write bank
//   wr_data       in   DATA_WIDTH  write data
//   wr_en         out  1           write grant pulse
//   rd_rq         in   1           read request (level, held until rd_en)
//   rd_end        in   1           read finished (pulse)
//   rd_cmd        in   4           read command
//   rd_addr       in   ADDR_WIDTH  read address
//   rd_bank_addr  in   2           read bank
//   rd_en         out  1           read grant pulse
//   sdram_cke     out  1           clock enable
//   sdram_cmd     out  4           {cs_n,ras_n,cas_n,we_n}
//   sdram_addr    out  ADDR_WIDTH  SDRAM address
//   sdram_bank    out  2           SDRAM bank address
//   sdram_dq_out  out  DATA_WIDTH  DQ drive value
//   sdram_dq_oe   out  1           DQ output enable
//   sdram_dq_in   in   DATA_WIDTH  DQ sampled value
//   rd_data       out  DATA_WIDTH  captured read word
//   rd_data_vld   out  1           rd_data valid, 1 cycle per word
// BEHAVIOUR
//   Reset values: state=INIT; all enables, sdram_cke, sdram_dq_oe and rd_data_vld are 0; rd_data is 0.
//   - sdram_cke goes to 1 on the first clk edge after reset release and stays 1.
//   State machine (registered), states INIT, IDLE, REF, WRITE, READ:
//   - INIT  -> IDLE when init_end=1.
//   - IDLE priority: ref_rq > wr_rq > rd_rq; go to REF / WRITE / READ respectively; no request -> stay.
//   - REF   -> IDLE on ref_end.  WRITE -> IDLE on wr_end.  READ -> IDLE on rd_end.
//   - An end pulse outside its own state is ignored.
//   Grant pulses (registered):
//   - x_en=1 for exactly one cycle, the cycle after the IDLE->x transition edge, i.e. the first cycle state==x.
//   - A requester that re-requests after its end pulse is re-arbitrated from IDLE; IDLE always lasts >= 1 cycle.
//   Bus mux (combinational from the state register, zero latency):
//   - INIT -> init_*; REF -> ref_*; WRITE -> wr_*; READ -> rd_*.
//   - IDLE -> CMD_NOP, addr 0, bank 0.
//   - init and ref bank = 2'b00.
//   Write data path:
//   - sdram_dq_oe = (state==WRITE && wr_cmd==CMD_WRITE).
//   - sdram_dq_out = wr_data when oe, else 0.
//   Read capture:
//   - CAS_LAT-deep shift register tags each cycle with (state==READ && rd_cmd==CMD_READ).
//   - Tag emerging at stage CAS_LAT: register sdram_dq_in into rd_data and pulse rd_data_vld on the next edge.
//   - Latency: READ cmd at cycle t -> rd_data_vld at t+CAS_LAT+1.
//   - Back-to-back READs give back-to-back valids.
//   - The capture pipeline keeps draining after the state leaves READ.
//   Reset mid-operation: all state and pipeline cleared immediately (asynchronous); in-flight read data is discarded; INIT re-entered.
// TESTING
//   1 Reset; init_end=1 at cycle 10 -> state IDLE at 11; sdram_cmd=init_cmd during 0..10, 4'b0111 after.
//   2 ref_rq, wr_rq, rd_rq all rise in the same IDLE cycle -> ref_en only; after ref_end, wr_en; after wr_end, rd_en.
//   3 rd_rq held, READ cmds on 4 consecutive cycles, DQ = 3,5,7,9 -> rd_data_vld 4 cycles starting CAS_LAT+1 after the first READ, data 3,5,7,9.
//   4 WRITE state with wr_cmd=4'b0100, wr_data=16'hA5A5 -> sdram_dq_oe=1, sdram_dq_out=16'hA5A5 that cycle; oe=0 on ACT/PRE cycles.
//   5 ref_rq rises during READ; read block issues rd_end then re-asserts rd_rq -> arbiter grants REF, then READ; no overlapping enables.
//   6 rst_n low 1 cycle after a READ cmd -> no rd_data_vld; outputs at reset values; state INIT.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Arbiter between the SDRAM init/refresh/write/read sub-controllers and the SDRAM pins.
// Latency: bus mux is combinational from state; grant pulses come one cycle after arbitration;
// read data appears CAS_LAT+1 cycles after the READ command. Requesters wait (hold _rq) until granted.
module sdram_arbiter #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 12,
  parameter int         CAS_LAT    = 3,
  parameter logic [3:0] CMD_NOP    = 4'b0111,
  parameter logic [3:0] CMD_READ   = 4'b0101,
  parameter logic [3:0] CMD_WRITE  = 4'b0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_end,
  input  logic [3:0]            init_cmd,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic                  ref_rq,
  input  logic                  ref_end,
  input  logic [3:0]            ref_cmd,
  input  logic [ADDR_WIDTH-1:0] ref_addr,
  output logic                  ref_en,
  input  logic                  wr_rq,
  input  logic                  wr_end,
  input  logic [3:0]            wr_cmd,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            wr_bank_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  rd_rq,
  input  logic                  rd_end,
  input  logic [3:0]            rd_cmd,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0]            rd_bank_addr,
  output logic                  rd_en,
  output logic                  sdram_cke,
  output logic [3:0]            sdram_cmd,
  output logic [ADDR_WIDTH-1:0] sdram_addr,
  output logic [1:0]            sdram_bank,
  output logic [DATA_WIDTH-1:0] sdram_dq_out,
  output logic                  sdram_dq_oe,
  input  logic [DATA_WIDTH-1:0] sdram_dq_in,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_vld
);

  typedef enum logic [2:0] {INIT, IDLE, REF, WRITE, READ} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               rd_issue;
  logic [CAS_LAT-1:0] rd_tag;

  // State register, one-cycle grant pulses on leaving IDLE, and clock enable after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      ref_en    <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      sdram_cke <= 1'b0;
    end else begin
      state     <= state_nxt;
      ref_en    <= (state == IDLE) && (state_nxt == REF);
      wr_en     <= (state == IDLE) && (state_nxt == WRITE);
      rd_en     <= (state == IDLE) && (state_nxt == READ);
      sdram_cke <= 1'b1;
    end
  end

  // Next-state: fixed priority refresh > write > read, each block returns to IDLE on its own end pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_end) state_nxt = IDLE;
      IDLE: begin
        if (ref_rq)     state_nxt = REF;
        else if (wr_rq) state_nxt = WRITE;
        else if (rd_rq) state_nxt = READ;
      end
      REF:     if (ref_end) state_nxt = IDLE;
      WRITE:   if (wr_end)  state_nxt = IDLE;
      READ:    if (rd_end)  state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  // Bus mux: the owning sub-controller drives cmd/addr/bank; IDLE parks the bus on NOP.
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_bank = 2'b00;
    case (state)
      INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      REF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank_addr;
      end
      default: ;
    endcase
  end

  // DQ is driven only on the WRITE command cycle itself, never during ACT/PRE of a write.
  always_comb begin
    sdram_dq_oe  = (state == WRITE) && (wr_cmd == CMD_WRITE);
    sdram_dq_out = sdram_dq_oe ? wr_data : '0;
  end

  assign rd_issue = (state == READ) && (rd_cmd == CMD_READ);

  // Tag pipeline tracks each READ for CAS_LAT cycles; it keeps draining after READ is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag      <= '0;
      rd_data     <= '0;
      rd_data_vld <= 1'b0;
    end else begin
      rd_tag      <= {rd_tag[CAS_LAT-2:0], rd_issue};
      rd_data_vld <= rd_tag[CAS_LAT-1];
      if (rd_tag[CAS_LAT-1]) rd_data <= sdram_dq_in;
    end
  end

endmodule
